// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the data-side memory bridge.
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        LOAD_REQ,
        LOAD_WAIT,
        DONE
    } bridge_state_t;

    localparam int unsigned XLEN_DEFAULT        = 32;
    localparam int unsigned STORE_DEPTH_DEFAULT = 4;

    // One strobe bit per data byte.
    function automatic int unsigned strb_width(input int unsigned xlen);
        return xlen / 8;
    endfunction

endpackage

// File: rtl/data_mem_bridge_if.sv
// Core-side and memory-side signals of the data bridge.
// master: the bridge itself; slave: the core plus external memory around it.
interface data_mem_bridge_if
    import mem_bridge_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);
    localparam int unsigned SW = strb_width(XLEN);

    logic            core_mem_en;
    logic            core_write_en;
    logic [SW-1:0]   core_byte_en;
    logic [XLEN-1:0] core_adr;
    logic [XLEN-1:0] core_wdata;
    logic [XLEN-1:0] core_rdata;
    logic            core_stall;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_write;
    logic [XLEN-1:0] mem_req_adr;
    logic [XLEN-1:0] mem_req_wdata;
    logic [SW-1:0]   mem_req_strb;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_rdata;

    modport master (
        input  core_mem_en, core_write_en, core_byte_en, core_adr, core_wdata,
        output core_rdata, core_stall,
        output mem_req_valid, mem_req_write, mem_req_adr, mem_req_wdata, mem_req_strb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        output core_mem_en, core_write_en, core_byte_en, core_adr, core_wdata,
        input  core_rdata, core_stall,
        input  mem_req_valid, mem_req_write, mem_req_adr, mem_req_wdata, mem_req_strb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

endinterface

// File: rtl/store_fifo.sv
// Posted-store buffer: circular FIFO of {adr, wdata, strb} entries.
module store_fifo
    import mem_bridge_pkg::*;
#(
    parameter  int unsigned XLEN  = XLEN_DEFAULT,
    parameter  int unsigned DEPTH = STORE_DEPTH_DEFAULT,
    localparam int unsigned SW    = strb_width(XLEN),
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [XLEN-1:0] push_adr,
    input  logic [XLEN-1:0] push_wdata,
    input  logic [SW-1:0]   push_strb,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count,
    output logic [XLEN-1:0] head_adr,
    output logic [XLEN-1:0] head_wdata,
    output logic [SW-1:0]   head_strb
);

    typedef struct packed {
        logic [XLEN-1:0] adr;
        logic [XLEN-1:0] wdata;
        logic [SW-1:0]   strb;
    } store_entry_t;

    store_entry_t entries [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_adr   = entries[head].adr;
    assign head_wdata = entries[head].wdata;
    assign head_strb  = entries[head].strb;

    // Entry storage; contents are don't-care while not counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[tail] <= '{adr: push_adr, wdata: push_wdata, strb: push_strb};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_bridge.sv
// Bridge between the core's single-cycle data port and a handshaked memory.
// Stores are posted into store_fifo; loads drain the FIFO, then stall the core.
module data_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter  int unsigned XLEN        = XLEN_DEFAULT,
    parameter  int unsigned STORE_DEPTH = STORE_DEPTH_DEFAULT,
    localparam int unsigned SW          = strb_width(XLEN),
    localparam int unsigned CW          = $clog2(STORE_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_bridge_if.master  bus
);

    bridge_state_t   state;
    logic [XLEN-1:0] rdata_q;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [XLEN-1:0] head_adr;
    logic [XLEN-1:0] head_wdata;
    logic [SW-1:0]   head_strb;

    logic            is_load;
    logic            drain_active;

    assign is_load      = bus.core_mem_en && !bus.core_write_en;
    assign drain_active = ((state == IDLE) || (state == DRAIN)) && !fifo_empty;
    // Full is judged before this cycle's pop, so a blocked store waits a cycle.
    assign fifo_push    = (state == IDLE) && bus.core_mem_en && bus.core_write_en && !fifo_full;
    assign fifo_pop     = drain_active && bus.mem_req_ready;

    store_fifo #(
        .XLEN  (XLEN),
        .DEPTH (STORE_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_adr   (bus.core_adr),
        .push_wdata (bus.core_wdata),
        .push_strb  (bus.core_byte_en),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head_adr   (head_adr),
        .head_wdata (head_wdata),
        .head_strb  (head_strb)
    );

    // Load sequencing FSM and the load-data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_load) state <= (fifo_count != '0) ? DRAIN : LOAD_REQ;
                end
                DRAIN: begin
                    if (fifo_empty || (fifo_pop && fifo_count == CW'(1))) state <= LOAD_REQ;
                end
                LOAD_REQ: begin
                    if (bus.mem_req_ready) state <= LOAD_WAIT;
                end
                LOAD_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        rdata_q <= bus.mem_rsp_rdata;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request mux (FIFO head vs pending load) and core stall decode.
    always_comb begin
        bus.mem_req_valid = 1'b0;
        bus.mem_req_write = 1'b0;
        bus.mem_req_adr   = '0;
        bus.mem_req_wdata = '0;
        bus.mem_req_strb  = '0;
        bus.core_stall    = 1'b0;

        if (drain_active) begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_write = 1'b1;
            bus.mem_req_adr   = head_adr;
            bus.mem_req_wdata = head_wdata;
            bus.mem_req_strb  = head_strb;
        end else if (state == LOAD_REQ) begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_adr   = bus.core_adr;
        end

        case (state)
            IDLE:                      bus.core_stall = bus.core_mem_en && (!bus.core_write_en || fifo_full);
            DRAIN, LOAD_REQ, LOAD_WAIT: bus.core_stall = 1'b1;
            default:                   bus.core_stall = 1'b0;
        endcase
    end

    assign bus.core_rdata = rdata_q;

endmodule
